// File: rtl/axi4_stream_pkt_gen.sv
// AXI4-Stream packet transmitter: accepts a length/seed/routing command and
// emits an incrementing-data packet with SOF on tuser[0] and EOP on tlast.
module axi4_stream_pkt_gen #(
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [LEN_WIDTH-1:0]     cmd_len,
    input  logic [TDATA_WIDTH-1:0]   cmd_seed,
    input  logic [TID_WIDTH-1:0]     cmd_tid,
    input  logic [TDEST_WIDTH-1:0]   cmd_tdest,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [TDATA_WIDTH-1:0]   m_tdata,
    output logic [TDATA_WIDTH/8-1:0] m_tstrb,
    output logic [TDATA_WIDTH/8-1:0] m_tkeep,
    output logic                     m_tlast,
    output logic [TID_WIDTH-1:0]     m_tid,
    output logic [TDEST_WIDTH-1:0]   m_tdest,
    output logic [TUSER_WIDTH-1:0]   m_tuser,
    output logic                     busy,
    output logic                     pkt_done
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [TDATA_WIDTH-1:0]  r_data;
    logic [LEN_WIDTH-1:0]    r_cnt;
    logic [LEN_WIDTH-1:0]    r_len;
    logic [TID_WIDTH-1:0]    r_tid;
    logic [TDEST_WIDTH-1:0]  r_tdest;
    logic                    r_first;
    logic                    r_last;
    logic                    r_done;
    logic                    w_send;
    logic                    w_accept;
    logic                    w_hs;
    logic [LEN_WIDTH-1:0]    w_cntNext;
    logic [TDATA_WIDTH-1:0]  w_dataNext;

    assign w_send     = (r_state == SEND);
    assign w_accept   = cmd_valid && (r_state == IDLE);
    assign w_hs       = w_send && m_tready;
    assign w_cntNext  = r_cnt + LEN_WIDTH'(1);
    assign w_dataNext = r_data + TDATA_WIDTH'(1);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Handshake signals depend on state only, so m_tready never reaches an output combinationally.
    always_comb begin
        w_stateNext = r_state;
        cmd_ready   = 1'b0;
        m_tvalid    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_stateNext = SEND;
                end
            end
            SEND: begin
                m_tvalid = 1'b1;
                busy     = 1'b1;
                if (m_tready && r_last) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Beat registers only move on acceptance or handshake, which keeps them stable under backpressure.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_data  <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_tid   <= '0;
            r_tdest <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_hs && r_last;
            if (w_accept) begin
                r_len   <= cmd_len;
                r_tid   <= cmd_tid;
                r_tdest <= cmd_tdest;
                r_data  <= cmd_seed;
                r_cnt   <= '0;
                r_first <= 1'b1;
                r_last  <= (cmd_len == '0);
            end else if (w_hs) begin
                r_first <= 1'b0;
                if (r_last) begin
                    r_last <= 1'b0;
                end else begin
                    r_data <= w_dataNext;
                    r_cnt  <= w_cntNext;
                    r_last <= (w_cntNext == r_len);
                end
            end
        end
    end

    always_comb begin
        m_tuser    = '0;
        m_tuser[0] = r_first;
    end

    assign m_tdata  = r_data;
    assign m_tstrb  = {(TDATA_WIDTH/8){w_send}};
    assign m_tkeep  = {(TDATA_WIDTH/8){w_send}};
    assign m_tlast  = r_last;
    assign m_tid    = r_tid;
    assign m_tdest  = r_tdest;
    assign pkt_done = r_done;

endmodule

// File: tb/tb_axi4_stream_pkt_gen.sv
// Directed bench for axi4_stream_pkt_gen: single beat, multi-beat, backpressure,
// data wrap with back-to-back commands, and asynchronous reset mid-packet.
module tb_axi4_stream_pkt_gen;

    logic        aclk;
    logic        areset;
    logic        cmdValid;
    logic        cmdReady;
    logic [15:0] cmdLen;
    logic [31:0] cmdSeed;
    logic [0:0]  cmdTid;
    logic [0:0]  cmdTdest;
    logic        mTvalid;
    logic        mTready;
    logic [31:0] mTdata;
    logic [3:0]  mTstrb;
    logic [3:0]  mTkeep;
    logic        mTlast;
    logic [0:0]  mTid;
    logic [0:0]  mTdest;
    logic [0:0]  mTuser;
    logic        busy;
    logic        pktDone;

    int vecCount = 0;
    int missCount = 0;

    axi4_stream_pkt_gen dut (
        .aclk      (aclk),
        .areset    (areset),
        .cmd_valid (cmdValid),
        .cmd_ready (cmdReady),
        .cmd_len   (cmdLen),
        .cmd_seed  (cmdSeed),
        .cmd_tid   (cmdTid),
        .cmd_tdest (cmdTdest),
        .m_tvalid  (mTvalid),
        .m_tready  (mTready),
        .m_tdata   (mTdata),
        .m_tstrb   (mTstrb),
        .m_tkeep   (mTkeep),
        .m_tlast   (mTlast),
        .m_tid     (mTid),
        .m_tdest   (mTdest),
        .m_tuser   (mTuser),
        .busy      (busy),
        .pkt_done  (pktDone)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            missCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] len, input logic [31:0] seed,
                                 input logic tid, input logic tdest);
        cmdValid = v;
        cmdLen   = len;
        cmdSeed  = seed;
        cmdTid   = tid;
        cmdTdest = tdest;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkBeat(input string tag, input logic [31:0] data, input logic first, input logic last);
        checkOutput({tag, " tvalid"}, 64'(mTvalid), 64'd1);
        checkOutput({tag, " tdata"},  64'(mTdata), 64'(data));
        checkOutput({tag, " tuser"},  64'(mTuser), 64'(first));
        checkOutput({tag, " tlast"},  64'(mTlast), 64'(last));
        checkOutput({tag, " cmd_ready"}, 64'(cmdReady), 64'd0);
    endtask

    task automatic checkIdleDone(input string tag);
        checkOutput({tag, " end tvalid"}, 64'(mTvalid), 64'd0);
        checkOutput({tag, " end pkt_done"}, 64'(pktDone), 64'd1);
        checkOutput({tag, " end cmd_ready"}, 64'(cmdReady), 64'd1);
        checkOutput({tag, " end tlast"}, 64'(mTlast), 64'd0);
        checkOutput({tag, " end tuser"}, 64'(mTuser), 64'd0);
    endtask

    initial begin
        logic [6:0] bpPattern;
        int beat;

        areset  = 1'b1;
        mTready = 1'b0;
        applyStimulus(1'b0, 16'd0, 32'd0, 1'b0, 1'b0);
        #12;
        checkOutput("reset cmd_ready", 64'(cmdReady), 64'd1);
        checkOutput("reset tvalid", 64'(mTvalid), 64'd0);
        checkOutput("reset tid", 64'(mTid), 64'd0);
        checkOutput("reset pkt_done", 64'(pktDone), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset tkeep", 64'(mTkeep), 64'd0);
        @(negedge aclk);
        areset = 1'b0;
        tick();

        // Single beat packet
        $display("[TB] single beat");
        mTready = 1'b1;
        applyStimulus(1'b1, 16'd0, 32'h000000A5, 1'b1, 1'b1);
        tick();
        cmdValid = 1'b0;
        checkBeat("single", 32'hA5, 1'b1, 1'b1);
        checkOutput("single tkeep", 64'(mTkeep), 64'hF);
        checkOutput("single tstrb", 64'(mTstrb), 64'hF);
        checkOutput("single tid", 64'(mTid), 64'd1);
        checkOutput("single tdest", 64'(mTdest), 64'd1);
        checkOutput("single busy", 64'(busy), 64'd1);
        tick();
        checkIdleDone("single");
        checkOutput("single busy low", 64'(busy), 64'd0);
        checkOutput("single tid hold", 64'(mTid), 64'd1);
        checkOutput("single tkeep idle", 64'(mTkeep), 64'd0);
        tick();
        checkOutput("single pkt_done pulse", 64'(pktDone), 64'd0);

        // Four beats without backpressure
        $display("[TB] four beats");
        applyStimulus(1'b1, 16'd3, 32'h00000010, 1'b0, 1'b0);
        tick();
        cmdValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkBeat($sformatf("four beat%0d", i), 32'h10 + 32'(i), (i == 0), (i == 3));
            tick();
        end
        checkIdleDone("four");
        checkOutput("four tid", 64'(mTid), 64'd0);

        // Backpressure: ready pattern 1,0,0,1,0,1,1 (bit 0 first)
        $display("[TB] backpressure");
        bpPattern = 7'b1101001;
        beat = 0;
        applyStimulus(1'b1, 16'd3, 32'h00000020, 1'b1, 1'b0);
        tick();
        cmdValid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            mTready = bpPattern[c];
            checkBeat($sformatf("bp cycle%0d", c), 32'h20 + 32'(beat), (beat == 0), (beat == 3));
            tick();
            if (bpPattern[c]) beat++;
        end
        checkOutput("bp handshakes", 64'(beat), 64'd4);
        checkIdleDone("bp");
        mTready = 1'b1;
        tick();

        // Data wrap, with a second command held during the first packet
        $display("[TB] wrap and back-to-back");
        applyStimulus(1'b1, 16'd2, 32'hFFFFFFFE, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 16'd1, 32'h00000055, 1'b1, 1'b0);
        checkBeat("wrap beat0", 32'hFFFFFFFE, 1'b1, 1'b0);
        tick();
        checkBeat("wrap beat1", 32'hFFFFFFFF, 1'b0, 1'b0);
        tick();
        checkBeat("wrap beat2", 32'h00000000, 1'b0, 1'b1);
        checkOutput("wrap tdest", 64'(mTdest), 64'd1);
        tick();
        checkIdleDone("wrap");
        tick();
        cmdValid = 1'b0;
        checkBeat("b2b beat0", 32'h55, 1'b1, 1'b0);
        checkOutput("b2b tid", 64'(mTid), 64'd1);
        checkOutput("b2b pkt_done low", 64'(pktDone), 64'd0);
        tick();
        checkBeat("b2b beat1", 32'h56, 1'b0, 1'b1);
        tick();
        checkIdleDone("b2b");
        tick();

        // Asynchronous reset in the middle of a packet
        $display("[TB] reset mid-packet");
        applyStimulus(1'b1, 16'd7, 32'h00000100, 1'b1, 1'b1);
        tick();
        cmdValid = 1'b0;
        tick();
        tick();
        tick();
        checkBeat("pre-reset beat3", 32'h103, 1'b0, 1'b0);
        #3;
        areset = 1'b1;
        #1;
        checkOutput("mid reset tvalid", 64'(mTvalid), 64'd0);
        checkOutput("mid reset tdata", 64'(mTdata), 64'd0);
        checkOutput("mid reset tlast", 64'(mTlast), 64'd0);
        checkOutput("mid reset tuser", 64'(mTuser), 64'd0);
        checkOutput("mid reset tid", 64'(mTid), 64'd0);
        checkOutput("mid reset tdest", 64'(mTdest), 64'd0);
        checkOutput("mid reset tkeep", 64'(mTkeep), 64'd0);
        checkOutput("mid reset busy", 64'(busy), 64'd0);
        checkOutput("mid reset cmd_ready", 64'(cmdReady), 64'd1);
        @(negedge aclk);
        areset = 1'b0;
        tick();
        checkOutput("post reset cmd_ready", 64'(cmdReady), 64'd1);
        checkOutput("post reset pkt_done", 64'(pktDone), 64'd0);
        applyStimulus(1'b1, 16'd1, 32'h00000000, 1'b0, 1'b0);
        tick();
        cmdValid = 1'b0;
        checkBeat("post reset beat0", 32'h0, 1'b1, 1'b0);
        tick();
        checkBeat("post reset beat1", 32'h1, 1'b0, 1'b1);
        tick();
        checkIdleDone("post reset");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
